// File: rtl/flow_table_nway.sv
// N-way set-associative flow table: 5-tuple hash lookup, SYN install, FIN/RST close.
// Optional FLOW_BIDIR_EN canonicalises keys so both directions share one entry.
module flow_table_nway #(
  parameter int W_KEY  = 104,
  parameter int W_FLAG = 8,
  parameter int D_HASH = 8,
  parameter int L_WAYS = 2,
  parameter int W_FID  = D_HASH + L_WAYS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_in_valid,
  input  logic [W_KEY-1:0]  key_in,
  input  logic [W_FLAG-1:0] flag_in,
  input  logic              del_valid,
  input  logic [W_FID-1:0]  del_flowID,
  output logic              res_valid,
  output logic              res_hit,
  output logic              res_add,
  output logic              res_full,
  output logic              res_close,
  output logic              res_dir,
  output logic [W_FID-1:0]  res_flowID,
  output logic [W_FID:0]    occupancy
);

  localparam int N_WAYS    = 1 << L_WAYS;
  localparam int N_BUCKETS = 1 << D_HASH;
  localparam int N_CHUNK   = (W_KEY + D_HASH - 1) / D_HASH;
  localparam int MAX_OCC   = N_WAYS * N_BUCKETS;

  logic [N_WAYS-1:0] valid_q [N_BUCKETS];
  logic [W_KEY-1:0]  key_q   [N_BUCKETS][N_WAYS];

  function automatic logic [D_HASH-1:0] fold_hash(input logic [W_KEY-1:0] k);
    logic [N_CHUNK*D_HASH-1:0] padded;
    logic [D_HASH-1:0]         h;
    padded = '0;
    padded[W_KEY-1:0] = k;
    h = '0;
    for (int unsigned i = 0; i < N_CHUNK; i++) h ^= padded[i*D_HASH +: D_HASH];
    return h;
  endfunction

  // S0: canonical key
  logic [W_KEY-1:0] canon_key;
  logic             canon_dir;

  always_comb begin
    canon_key = key_in;
    canon_dir = 1'b0;
`ifdef FLOW_BIDIR_EN
    if ({key_in[103:72], key_in[39:24]} > {key_in[71:40], key_in[23:8]}) begin
      canon_key = {key_in[71:40], key_in[103:72], key_in[23:8], key_in[39:24], key_in[7:0]};
      canon_dir = 1'b1;
    end
`endif
  end

  logic              s1_valid;
  logic [W_KEY-1:0]  s1_key;
  logic              s1_fin_rst;
  logic              s1_syn_only;
  logic [D_HASH-1:0] s1_hash;
  logic              s1_dir;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_key      <= '0;
      s1_fin_rst  <= 1'b0;
      s1_syn_only <= 1'b0;
      s1_hash     <= '0;
      s1_dir      <= 1'b0;
    end else begin
      s1_valid    <= key_in_valid;
      s1_key      <= canon_key;
      s1_fin_rst  <= flag_in[0] | flag_in[2];
      s1_syn_only <= flag_in[1] & ~flag_in[4];
      s1_hash     <= fold_hash(canon_key);
      s1_dir      <= canon_dir;
    end
  end

  logic unused_flags;
  assign unused_flags = ^flag_in;

  // S1: parallel compare against every way of the bucket
  logic [N_WAYS-1:0] bucket_valid;
  logic              hit_any;
  logic [L_WAYS-1:0] hit_way;
  logic              free_any;
  logic [L_WAYS-1:0] free_way;
  logic              do_close;
  logic              do_add;
  logic              do_full;
  logic [W_FID-1:0]  s1_fid;

  always_comb begin
    bucket_valid = valid_q[s1_hash];
    hit_any  = 1'b0;
    hit_way  = '0;
    free_any = 1'b0;
    free_way = '0;
    for (int unsigned w = 0; w < N_WAYS; w++) begin
      if (!hit_any && bucket_valid[w] && key_q[s1_hash][w] == s1_key) begin
        hit_any = 1'b1;
        hit_way = L_WAYS'(w);
      end
      if (!free_any && !bucket_valid[w]) begin
        free_any = 1'b1;
        free_way = L_WAYS'(w);
      end
    end
    do_close = s1_valid & hit_any & s1_fin_rst;
    do_add   = s1_valid & ~hit_any & s1_syn_only & free_any;
    do_full  = s1_valid & ~hit_any & s1_syn_only & ~free_any;
    if (hit_any)     s1_fid = {s1_hash, hit_way};
    else if (do_add) s1_fid = {s1_hash, free_way};
    else             s1_fid = '0;
  end

  logic [D_HASH-1:0] del_bucket;
  logic [L_WAYS-1:0] del_way;
  logic              del_live;
  logic              close_counts;
  logic [1:0]        dec;
  logic [W_FID+1:0]  occ_sum;
  logic [W_FID:0]    occ_next;

  // A close and a delete of the same live entry invalidate it only once.
  always_comb begin
    del_bucket   = del_flowID[W_FID-1:L_WAYS];
    del_way      = del_flowID[L_WAYS-1:0];
    del_live     = del_valid & valid_q[del_bucket][del_way];
    close_counts = do_close & ~(del_live && del_bucket == s1_hash && del_way == hit_way);
    dec          = 2'(del_live) + 2'(close_counts);
    occ_sum      = (W_FID+2)'(occupancy) + (W_FID+2)'(do_add);
    if (occ_sum < (W_FID+2)'(dec))            occ_next = '0;
    else if (occ_sum - (W_FID+2)'(dec) > (W_FID+2)'(MAX_OCC)) occ_next = (W_FID+1)'(MAX_OCC);
    else                                       occ_next = (W_FID+1)'(occ_sum - (W_FID+2)'(dec));
  end

  // Delete is applied before the S1 install so an add into a freed-invalid slot wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned b = 0; b < N_BUCKETS; b++) valid_q[b] <= '0;
    end else begin
      if (del_valid) valid_q[del_bucket][del_way] <= 1'b0;
      if (do_close)  valid_q[s1_hash][hit_way]    <= 1'b0;
      if (do_add)    valid_q[s1_hash][free_way]   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_add) key_q[s1_hash][free_way] <= s1_key;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_next;
    end
  end

  // S2: result registers hold between strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid  <= 1'b0;
      res_hit    <= 1'b0;
      res_add    <= 1'b0;
      res_full   <= 1'b0;
      res_close  <= 1'b0;
      res_dir    <= 1'b0;
      res_flowID <= '0;
    end else begin
      res_valid <= s1_valid;
      if (s1_valid) begin
        res_hit    <= hit_any;
        res_add    <= do_add;
        res_full   <= do_full;
        res_close  <= do_close;
        res_dir    <= s1_dir;
        res_flowID <= s1_fid;
      end
    end
  end

endmodule
